mole_input_encoder: RTL and testbench

Debounces and encodes the five player mole buttons into the one-hot-free 3-bit hit code consumed by the match logic in the main datapath. Each raw button is synchronised, debounced and edge-detected, and at most one press is issued at a time. The press is issued as a code held for a fixed number of cycles, so the downstream per-clock match sees it for a bounded window. The block sits between the board switch/key pins and the datapath `userGameInput` port.

---
 rtl/mole_pkg.sv | 29 ++
 rtl/debounce_bit.sv | 49 ++++
 rtl/mole_input_encoder.sv | 94 +++++++++
 tb/tb_mole_input_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared mole constants, hit codes and encoder state type
package mole_pkg;

    localparam int NUM_MOLES = 5;

    localparam logic [2:0] HIT_NONE  = 3'b000;
    localparam logic [2:0] HIT_MOLE1 = 3'b001;
    localparam logic [2:0] HIT_MOLE2 = 3'b010;
    localparam logic [2:0] HIT_MOLE3 = 3'b011;
    localparam logic [2:0] HIT_MOLE4 = 3'b100;
    localparam logic [2:0] HIT_MOLE5 = 3'b101;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } enc_state_e;

    function automatic logic [2:0] mole_code(input int idx);
        case (idx)
            0:       return HIT_MOLE1;
            1:       return HIT_MOLE2;
            2:       return HIT_MOLE3;
            3:       return HIT_MOLE4;
            4:       return HIT_MOLE5;
            default: return HIT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser plus counter debounce for one button
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Rise is taken from next-state so the hit can register on the same edge as the debounced level.
    assign rise_o  = level_d & ~level_q;
    assign level_o = level_q;

endmodule

// File: rtl/mole_input_encoder.sv
// rtl/mole_input_encoder.sv - debounced, priority-encoded mole hit code with fixed hold window
module mole_input_encoder
    import mole_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [NUM_MOLES-1:0] rawPress,
    input  logic                 gameActive,
    output logic [2:0]           hit,
    output logic                 hitValid,
    output logic [NUM_MOLES-1:0] debounced,
    output logic                 dropped
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [NUM_MOLES-1:0] rise;
    logic [2:0]           win_code;
    logic                 multi_event;

    enc_state_e           state_q;
    logic [2:0]           hit_q;
    logic                 hit_valid_q;
    logic                 dropped_q;
    logic [HOLD_W-1:0]    hold_cnt_q;

    for (genvar i = 0; i < NUM_MOLES; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock  (clock),
            .resetn (resetn),
            .raw_i  (rawPress[i]),
            .level_o(debounced[i]),
            .rise_o (rise[i])
        );
    end

    // Descending scan so the lowest-index event ends up as the winner.
    always_comb begin
        win_code = HIT_NONE;
        for (int i = NUM_MOLES - 1; i >= 0; i--) begin
            if (rise[i]) win_code = mole_code(i);
        end
        multi_event = (rise & (rise - NUM_MOLES'(1))) != '0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_READY;
            hit_q       <= HIT_NONE;
            hit_valid_q <= 1'b0;
            dropped_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            dropped_q <= 1'b0;
            case (state_q)
                ST_READY: begin
                    if (gameActive && win_code != HIT_NONE) begin
                        hit_q       <= win_code;
                        hit_valid_q <= 1'b1;
                        hold_cnt_q  <= HOLD_LOAD;
                        dropped_q   <= multi_event;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    dropped_q <= |rise;
                    if (!gameActive || hold_cnt_q == '0) begin
                        hit_q       <= HIT_NONE;
                        hit_valid_q <= 1'b0;
                        state_q     <= ST_READY;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                default: begin
                    hit_q       <= HIT_NONE;
                    hit_valid_q <= 1'b0;
                    state_q     <= ST_READY;
                end
            endcase
        end
    end

    assign hit      = hit_q;
    assign hitValid = hit_valid_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_mole_input_encoder.sv
// tb/tb_mole_input_encoder.sv - bench for mole_input_encoder against a history-based reference model
module tb_mole_input_encoder;

    localparam int DB = 4;
    localparam int HC = 3;

    logic       clock;
    logic       resetn;
    logic [4:0] rawPress;
    logic       gameActive;
    logic [2:0] hit;
    logic       hitValid;
    logic [4:0] debounced;
    logic       dropped;

    int n_tests = 0;
    int n_fail  = 0;

    mole_input_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HC)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .rawPress  (rawPress),
        .gameActive(gameActive),
        .hit       (hit),
        .hitValid  (hitValid),
        .debounced (debounced),
        .dropped   (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: raw vectors captured per edge; a level flips once the
    // DB most recent synchronised samples (two edges old) all disagree with it.
    logic [4:0] hist[$];
    logic [4:0] m_level;
    logic [2:0] m_hit;
    logic       m_drop;
    int         m_issue;
    int         edge_n;

    always @(posedge clock or negedge resetn) begin : model
        logic [4:0] ev;
        logic [4:0] smp;
        logic       all_diff;
        int         k;
        if (!resetn) begin
            hist.delete();
            m_level = '0;
            m_hit   = '0;
            m_drop  = 1'b0;
            m_issue = 0;
            edge_n  = 0;
        end else begin
            hist.push_back(rawPress);
            if (hist.size() > DB + 6) void'(hist.pop_front());
            edge_n++;
            ev = '0;
            for (int b = 0; b < 5; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    k = hist.size() - 3 - j;
                    if (k >= 0) smp = hist[k]; else smp = '0;
                    if (smp[b] == m_level[b]) all_diff = 1'b0;
                end
                if (all_diff && !m_level[b]) ev[b] = 1'b1;
                if (all_diff) m_level[b] = ~m_level[b];
            end
            m_drop = 1'b0;
            if (m_hit != 0) begin
                if (ev != 0) m_drop = 1'b1;
                if (!gameActive || (edge_n - m_issue) == HC) m_hit = '0;
            end else if (gameActive && ev != 0) begin
                for (int b = 4; b >= 0; b--) if (ev[b]) m_hit = 3'(b + 1);
                m_issue = edge_n;
                m_drop  = ($countones(ev) > 1);
            end
        end
    end

    always @(negedge clock) begin
        if (resetn) begin
            chk("model_hit", {5'b0, hit}, {5'b0, m_hit});
            chk("model_hitValid", {7'b0, hitValid}, {7'b0, (m_hit != 0)});
            chk("model_debounced", {3'b0, debounced}, {3'b0, m_level});
            chk("model_dropped", {7'b0, dropped}, {7'b0, m_drop});
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        resetn     = 1'b0;
        rawPress   = '0;
        gameActive = 1'b1;
        #2;
        chk("reset_hit", {5'b0, hit}, 8'h00);
        chk("reset_hitValid", {7'b0, hitValid}, 8'h00);
        chk("reset_debounced", {3'b0, debounced}, 8'h00);
        chk("reset_dropped", {7'b0, dropped}, 8'h00);
        edges(3);
        @(negedge clock) resetn = 1'b1;
        edges(3);

        // single press
        @(negedge clock) rawPress = 5'b00100;
        edges(5);
        chk("single_deb_e4", {3'b0, debounced}, 8'h00);
        chk("single_hit_e4", {5'b0, hit}, 8'h00);
        edges(1);
        chk("single_deb_e5", {3'b0, debounced}, 8'h04);
        chk("single_hit_e5", {5'b0, hit}, 8'h03);
        chk("single_valid_e5", {7'b0, hitValid}, 8'h01);
        edges(2);
        chk("single_hit_e7", {5'b0, hit}, 8'h03);
        edges(1);
        chk("single_hit_e8", {5'b0, hit}, 8'h00);
        @(negedge clock) rawPress = '0;
        edges(10);

        // simultaneous press
        @(negedge clock) rawPress = 5'b10010;
        edges(6);
        chk("simul_hit_e5", {5'b0, hit}, 8'h02);
        chk("simul_drop_e5", {7'b0, dropped}, 8'h01);
        edges(1);
        chk("simul_drop_e6", {7'b0, dropped}, 8'h00);
        edges(2);
        chk("simul_hit_e8", {5'b0, hit}, 8'h00);
        edges(6);
        chk("simul_no_mole5", {5'b0, hit}, 8'h00);
        @(negedge clock) rawPress = '0;
        edges(10);

        // press during hold
        @(negedge clock) rawPress = 5'b00001;
        edges(1);
        @(negedge clock) rawPress = 5'b01001;
        edges(5);
        chk("hold_hit_e5", {5'b0, hit}, 8'h01);
        edges(1);
        chk("hold_drop_e6", {7'b0, dropped}, 8'h01);
        chk("hold_hit_e6", {5'b0, hit}, 8'h01);
        edges(2);
        chk("hold_hit_e8", {5'b0, hit}, 8'h00);
        edges(5);
        chk("hold_no_mole4", {5'b0, hit}, 8'h00);
        @(negedge clock) rawPress = '0;
        edges(10);

        // glitch shorter than debounce window
        @(negedge clock) rawPress = 5'b00001;
        edges(3);
        @(negedge clock) rawPress = '0;
        edges(8);
        chk("glitch_deb", {3'b0, debounced}, 8'h00);
        chk("glitch_hit", {5'b0, hit}, 8'h00);

        // gating by gameActive
        @(negedge clock) begin gameActive = 1'b0; rawPress = 5'b00010; end
        edges(10);
        @(negedge clock) gameActive = 1'b1;
        edges(10);
        chk("gate_held_hit", {5'b0, hit}, 8'h00);
        chk("gate_held_deb", {3'b0, debounced}, 8'h02);
        @(negedge clock) rawPress = '0;
        edges(8);
        @(negedge clock) rawPress = 5'b00010;
        edges(6);
        chk("gate_repress_hit", {5'b0, hit}, 8'h02);
        @(negedge clock) rawPress = '0;
        edges(10);

        // asynchronous reset mid-hold
        @(negedge clock) rawPress = 5'b10000;
        edges(6);
        chk("rst_pre_hit", {5'b0, hit}, 8'h05);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_hit", {5'b0, hit}, 8'h00);
        chk("rst_async_valid", {7'b0, hitValid}, 8'h00);
        chk("rst_async_deb", {3'b0, debounced}, 8'h00);
        @(negedge clock) resetn = 1'b1;
        edges(6);
        chk("rst_reissue_hit", {5'b0, hit}, 8'h05);
        @(negedge clock) rawPress = '0;
        edges(10);

        // randomized traffic, checked by the model every cycle
        repeat (3000) begin
            @(negedge clock);
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 9) == 0) rawPress[b] = ~rawPress[b];
            if ($urandom_range(0, 59) == 0) gameActive = ~gameActive;
        end
        @(negedge clock) begin rawPress = '0; gameActive = 1'b1; end
        edges(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
